// File: rtl/pfr_spi_bypass_sequencer_pkg.sv
// Shared types and helpers for the PFR SPI bypass sequencer.
// Contents: sequencer state enum, mux-select encodings, and the width
// helper for the shared hold/settle down-counter.
package pfr_bypass_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_PFR,
        ST_RST_ASSERT,
        ST_SWITCH,
        ST_BYPASS
    } state_t;

    localparam logic SEL_PFR  = 1'b1;
    localparam logic SEL_HOST = 1'b0;

    // Bits needed to hold the larger of the two phase lengths.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pfr_spi_bypass_sequencer_if.sv
// Bus bundle between the PFR core / host chip selects and the flash pins.
// slave : used by pfr_spi_bypass_sequencer (requests and CS in, pins out).
// master: used by the driving side (requests and CS out, pins in).
interface pfr_spi_bypass_sequencer_if #(
    parameter int unsigned NUM_CH = 2
);
    logic              iBypassReq;
    logic [NUM_CH-1:0] iPfrCs_n;
    logic [NUM_CH-1:0] iHostCs_n;
    logic [NUM_CH-1:0] oSecureCs_n;
    logic [NUM_CH-1:0] oMasterSel;
    logic [NUM_CH-1:0] oSpiRst_n;
    logic              oExtRst_n;
    logic              oBypassActive;
    logic              oBusy;

    modport slave (
        input  iBypassReq, iPfrCs_n, iHostCs_n,
        output oSecureCs_n, oMasterSel, oSpiRst_n, oExtRst_n, oBypassActive, oBusy
    );

    modport master (
        output iBypassReq, iPfrCs_n, iHostCs_n,
        input  oSecureCs_n, oMasterSel, oSpiRst_n, oExtRst_n, oBypassActive, oBusy
    );
endinterface

// File: rtl/pfr_spi_bypass_sequencer_cs_idle_monitor.sv
// pfr_cs_idle_monitor: flags when every host chip select has been high for
// CS_IDLE_CYC consecutive cycles. Any low CS restarts the count.
// Ports: iClk, iRst_n (async active-low), iHostCs_n (channels to watch;
// channels not of interest should be tied high), oIdle (registered).
module pfr_cs_idle_monitor #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CS_IDLE_CYC = 8
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic [NUM_CH-1:0] iHostCs_n,
    output logic              oIdle
);
    localparam int unsigned CNT_W = $clog2(CS_IDLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CS_IDLE_CYC);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;

    // Saturating count of consecutive all-high cycles.
    always_comb begin
        cnt_nx = '0;
        if (&iHostCs_n) begin
            cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            cnt   <= '0;
            oIdle <= 1'b0;
        end else begin
            cnt   <= cnt_nx;
            oIdle <= (cnt_nx == CNT_MAX);
        end
    end
endmodule

// File: rtl/pfr_spi_bypass_sequencer.sv
// pfr_spi_bypass_sequencer: hands NUM_CH SPI flash channels between the PFR
// master and the host masters through a timed reset/switch/release sequence.
// Ports: iClk, iRst_n (async active-low), bus (pfr_spi_bypass_sequencer_if.slave:
// iBypassReq, iPfrCs_n, iHostCs_n in; oSecureCs_n, oMasterSel, oSpiRst_n,
// oExtRst_n, oBypassActive, oBusy out, all registered).
// Option: PFR_BYPASS_CS_IDLE_CHECK_EN gates each handover on the masked host
// chip selects having been idle for CS_IDLE_CYC cycles.
module pfr_spi_bypass_sequencer
    import pfr_bypass_pkg::*;
#(
    parameter int unsigned       NUM_CH         = 2,
    parameter logic [NUM_CH-1:0] CH_BYPASS_MASK = '1,
    parameter int unsigned       RST_HOLD_CYC   = 200,
    parameter int unsigned       SEL_SETTLE_CYC = 16,
    parameter int unsigned       CS_IDLE_CYC    = 8
) (
    input  logic                       iClk,
    input  logic                       iRst_n,
    pfr_spi_bypass_sequencer_if.slave  bus
);
    localparam int unsigned      CNT_W    = cnt_width(RST_HOLD_CYC, SEL_SETTLE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] SETTL_LD = CNT_W'(SEL_SETTLE_CYC - 1);
    localparam logic [NUM_CH-1:0] MASK    = CH_BYPASS_MASK;

    // Elaboration-time parameter sanity.
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("NUM_CH must be 1..8");
    end
    if (RST_HOLD_CYC < 1 || SEL_SETTLE_CYC < 1 || CS_IDLE_CYC < 1) begin : g_bad_cyc
        $error("cycle parameters must be >= 1");
    end

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             to_host, to_host_nx;
    logic             host_idle;

    logic [NUM_CH-1:0] sel_nx, spi_rst_nx, cs_nx;
    logic              ext_nx, act_nx, busy_nx;
    logic              sel_bit;

`ifdef PFR_BYPASS_CS_IDLE_CHECK_EN
    logic [NUM_CH-1:0] watched_cs;
    logic              idle_hist;

    // Unmasked channels never block a handover.
    assign watched_cs = bus.iHostCs_n | ~MASK;

    pfr_cs_idle_monitor #(
        .NUM_CH      (NUM_CH),
        .CS_IDLE_CYC (CS_IDLE_CYC)
    ) u_idle (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iHostCs_n (watched_cs),
        .oIdle     (idle_hist)
    );

    // History says idle and nothing has gone low in the current cycle.
    assign host_idle = idle_hist & (&watched_cs);
`else
    assign host_idle = 1'b1;
`endif

    // State, phase counter and handover direction.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state   <= ST_INIT;
            cnt     <= HOLD_LD;
            to_host <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            to_host <= to_host_nx;
        end
    end

    // Next state; the counter saturates at zero and is reloaded on entry.
    always_comb begin
        state_nx   = state;
        cnt_nx     = (cnt == '0) ? cnt : cnt - 1'b1;
        to_host_nx = to_host;
        case (state)
            ST_INIT: begin
                if (cnt == '0) begin
                    state_nx = ST_PFR;
                    cnt_nx   = '0;
                end
            end
            ST_PFR: begin
                if (bus.iBypassReq && host_idle) begin
                    state_nx   = ST_RST_ASSERT;
                    cnt_nx     = HOLD_LD;
                    to_host_nx = 1'b1;
                end
            end
            ST_RST_ASSERT: begin
                if (cnt == '0) begin
                    state_nx = ST_SWITCH;
                    cnt_nx   = SETTL_LD;
                end
            end
            ST_SWITCH: begin
                if (cnt == '0) begin
                    state_nx = to_host ? ST_BYPASS : ST_PFR;
                    cnt_nx   = '0;
                end
            end
            ST_BYPASS: begin
                if (!bus.iBypassReq && host_idle) begin
                    state_nx   = ST_RST_ASSERT;
                    cnt_nx     = HOLD_LD;
                    to_host_nx = 1'b0;
                end
            end
            default: begin
                state_nx = ST_INIT;
                cnt_nx   = HOLD_LD;
            end
        endcase
    end

    // Output decode from the next state so the pins track the state register.
    // ST_INIT resets every flash; elsewhere unmasked channels stay with the PFR.
    always_comb begin
        sel_nx     = '1;
        spi_rst_nx = '1;
        cs_nx      = bus.iPfrCs_n;
        ext_nx     = 1'b1;
        act_nx     = 1'b0;
        busy_nx    = 1'b0;
        sel_bit    = SEL_PFR;
        case (state_nx)
            ST_PFR: begin
            end
            ST_RST_ASSERT: begin
                // Select still holds the side being handed away.
                sel_bit    = to_host_nx ? SEL_PFR : SEL_HOST;
                sel_nx     = (MASK & {NUM_CH{sel_bit}}) | (~MASK & {NUM_CH{SEL_PFR}});
                spi_rst_nx = ~MASK;
                cs_nx      = bus.iPfrCs_n | MASK;
                ext_nx     = 1'b0;
                busy_nx    = 1'b1;
            end
            ST_SWITCH: begin
                sel_bit    = to_host_nx ? SEL_HOST : SEL_PFR;
                sel_nx     = (MASK & {NUM_CH{sel_bit}}) | (~MASK & {NUM_CH{SEL_PFR}});
                spi_rst_nx = ~MASK;
                cs_nx      = bus.iPfrCs_n | MASK;
                ext_nx     = 1'b0;
                busy_nx    = 1'b1;
            end
            ST_BYPASS: begin
                sel_bit = SEL_HOST;
                sel_nx  = (MASK & {NUM_CH{sel_bit}}) | (~MASK & {NUM_CH{SEL_PFR}});
                cs_nx   = (bus.iPfrCs_n & ~MASK) | (bus.iHostCs_n & MASK);
                act_nx  = 1'b1;
            end
            default: begin
                spi_rst_nx = '0;
                cs_nx      = '1;
                ext_nx     = 1'b0;
                busy_nx    = 1'b1;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            bus.oMasterSel    <= '1;
            bus.oSpiRst_n     <= '0;
            bus.oSecureCs_n   <= '1;
            bus.oExtRst_n     <= 1'b0;
            bus.oBypassActive <= 1'b0;
            bus.oBusy         <= 1'b1;
        end else begin
            bus.oMasterSel    <= sel_nx;
            bus.oSpiRst_n     <= spi_rst_nx;
            bus.oSecureCs_n   <= cs_nx;
            bus.oExtRst_n     <= ext_nx;
            bus.oBypassActive <= act_nx;
            bus.oBusy         <= busy_nx;
        end
    end
endmodule

// File: tb/tb_pfr_spi_bypass_sequencer.sv
// Bench for pfr_spi_bypass_sequencer: NUM_CH=2, mask 2'b01, hold 4, settle 2.
module tb_pfr_spi_bypass_sequencer;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    pfr_spi_bypass_sequencer_if #(.NUM_CH(2)) bus_if ();

    pfr_spi_bypass_sequencer #(
        .NUM_CH         (2),
        .CH_BYPASS_MASK (2'b01),
        .RST_HOLD_CYC   (4),
        .SEL_SETTLE_CYC (2),
        .CS_IDLE_CYC    (8)
    ) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic [1:0] pfr_cs;
        logic [1:0] host_cs;
        logic [1:0] cs;
        logic [1:0] sel;
        logic [1:0] rst;
        logic       act;
        logic       busy;
        logic       ext;
    } vec_t;

    vec_t vec [18];

    function automatic vec_t mk(input logic r, input logic [1:0] p, input logic [1:0] h,
                                input logic [1:0] c, input logic [1:0] s, input logic [1:0] rs,
                                input logic a, input logic b, input logic e);
        vec_t v;
        v.req = r; v.pfr_cs = p; v.host_cs = h;
        v.cs = c; v.sel = s; v.rst = rs; v.act = a; v.busy = b; v.ext = e;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_sel"},  8'(bus_if.oMasterSel), 8'h3);
        chk({tag, "_rst"},  8'(bus_if.oSpiRst_n), 8'h0);
        chk({tag, "_cs"},   8'(bus_if.oSecureCs_n), 8'h3);
        chk({tag, "_ext"},  8'(bus_if.oExtRst_n), 8'h0);
        chk({tag, "_act"},  8'(bus_if.oBypassActive), 8'h0);
        chk({tag, "_busy"}, 8'(bus_if.oBusy), 8'h1);
    endtask

    // Releases reset now and checks the four INIT cycles plus PFR entry.
    task automatic init_check(input string tag);
        rst_n = 1'b1;
        #1;
        chk({tag, "_init_rst0"}, 8'(bus_if.oSpiRst_n), 8'h0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk({tag, "_init_rst"},  8'(bus_if.oSpiRst_n), 8'h0);
            chk({tag, "_init_sel"},  8'(bus_if.oMasterSel), 8'h3);
            chk({tag, "_init_busy"}, 8'(bus_if.oBusy), 8'h1);
        end
        tick();
        chk({tag, "_pfr_rst"},  8'(bus_if.oSpiRst_n), 8'h3);
        chk({tag, "_pfr_sel"},  8'(bus_if.oMasterSel), 8'h3);
        chk({tag, "_pfr_busy"}, 8'(bus_if.oBusy), 8'h0);
        chk({tag, "_pfr_ext"},  8'(bus_if.oExtRst_n), 8'h1);
        chk({tag, "_pfr_cs"},   8'(bus_if.oSecureCs_n), 8'(bus_if.iPfrCs_n));
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        total = 0;
        bad = 0;
        bus_if.iBypassReq = 1'b0;
        bus_if.iPfrCs_n   = 2'b10;
        bus_if.iHostCs_n  = 2'b11;

        //           req  pfr    host   cs     sel    rst   act busy ext
        vec[0]  = mk(0, 2'b10, 2'b11, 2'b10, 2'b11, 2'b11, 0, 0, 1);
        vec[1]  = mk(0, 2'b01, 2'b11, 2'b01, 2'b11, 2'b11, 0, 0, 1);
        vec[2]  = mk(1, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 0, 1, 0);
        vec[3]  = mk(1, 2'b01, 2'b00, 2'b01, 2'b11, 2'b10, 0, 1, 0);
        vec[4]  = mk(1, 2'b11, 2'b00, 2'b11, 2'b11, 2'b10, 0, 1, 0);
        vec[5]  = mk(1, 2'b10, 2'b00, 2'b11, 2'b11, 2'b10, 0, 1, 0);
        vec[6]  = mk(1, 2'b11, 2'b00, 2'b11, 2'b10, 2'b10, 0, 1, 0);
        vec[7]  = mk(1, 2'b01, 2'b00, 2'b01, 2'b10, 2'b10, 0, 1, 0);
        vec[8]  = mk(1, 2'b01, 2'b10, 2'b00, 2'b10, 2'b11, 1, 0, 1);
        vec[9]  = mk(1, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 1, 0, 1);
        vec[10] = mk(1, 2'b00, 2'b11, 2'b01, 2'b10, 2'b11, 1, 0, 1);
        vec[11] = mk(0, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 0, 1, 0);
        vec[12] = mk(0, 2'b01, 2'b11, 2'b01, 2'b10, 2'b10, 0, 1, 0);
        vec[13] = mk(0, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 0, 1, 0);
        vec[14] = mk(0, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 0, 1, 0);
        vec[15] = mk(0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 0, 1, 0);
        vec[16] = mk(0, 2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 0, 1, 0);
        vec[17] = mk(0, 2'b10, 2'b11, 2'b10, 2'b11, 2'b11, 0, 0, 1);

        // Power-on reset and INIT sequence.
        tick();
        tick();
        chk_reset_values("por");
        init_check("por");

        // Full forward and return handover, one row per cycle.
        for (int i = 0; i < 18; i++) begin
`ifdef PFR_BYPASS_CS_IDLE_CHECK_EN
            if (i == 2 || i == 11) repeat (10) tick();
`endif
            bus_if.iBypassReq = vec[i].req;
            bus_if.iPfrCs_n   = vec[i].pfr_cs;
            bus_if.iHostCs_n  = vec[i].host_cs;
            tick();
            chk($sformatf("row%0d_cs", i),   8'(bus_if.oSecureCs_n), 8'(vec[i].cs));
            chk($sformatf("row%0d_sel", i),  8'(bus_if.oMasterSel), 8'(vec[i].sel));
            chk($sformatf("row%0d_rst", i),  8'(bus_if.oSpiRst_n), 8'(vec[i].rst));
            chk($sformatf("row%0d_act", i),  8'(bus_if.oBypassActive), 8'(vec[i].act));
            chk($sformatf("row%0d_busy", i), 8'(bus_if.oBusy), 8'(vec[i].busy));
            chk($sformatf("row%0d_ext", i),  8'(bus_if.oExtRst_n), 8'(vec[i].ext));
        end

`ifndef PFR_BYPASS_CS_IDLE_CHECK_EN
        // Request pulse inside RST_ASSERT: forward completes, return follows at once.
        bus_if.iPfrCs_n  = 2'b11;
        bus_if.iHostCs_n = 2'b11;
        bus_if.iBypassReq = 1'b1;               // cycle k
        tick();                                  // k+1
        chk("pulse_busy_k1", 8'(bus_if.oBusy), 8'h1);
        tick();                                  // k+2
        bus_if.iBypassReq = 1'b0;
        repeat (5) tick();                       // k+7
        chk("pulse_act_k7", 8'(bus_if.oBypassActive), 8'h1);
        chk("pulse_sel_k7", 8'(bus_if.oMasterSel), 8'h2);
        tick();                                  // k+8
        chk("pulse_busy_k8", 8'(bus_if.oBusy), 8'h1);
        chk("pulse_act_k8",  8'(bus_if.oBypassActive), 8'h0);
        chk("pulse_sel_k8",  8'(bus_if.oMasterSel), 8'h2);
        repeat (5) tick();                       // k+13
        chk("pulse_busy_k13", 8'(bus_if.oBusy), 8'h1);
        chk("pulse_sel_k13",  8'(bus_if.oMasterSel), 8'h3);
        tick();                                  // k+14
        chk("pulse_busy_k14", 8'(bus_if.oBusy), 8'h0);
        chk("pulse_rst_k14",  8'(bus_if.oSpiRst_n), 8'h3);
        chk("pulse_act_k14",  8'(bus_if.oBypassActive), 8'h0);
`endif

        // Reset asserted during ST_SWITCH.
        bus_if.iPfrCs_n  = 2'b01;
        bus_if.iHostCs_n = 2'b11;
        repeat (10) tick();
        bus_if.iBypassReq = 1'b1;
        repeat (5) tick();                       // k+5: SWITCH
        chk("mid_sel_switch", 8'(bus_if.oMasterSel), 8'h2);
        chk("mid_rst_switch", 8'(bus_if.oSpiRst_n), 8'h2);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_values("mid");
        bus_if.iBypassReq = 1'b0;
        tick();
        chk_reset_values("mid_hold");
        init_check("mid");

`ifdef PFR_BYPASS_CS_IDLE_CHECK_EN
        // Host CS busy blocks the handover; a low pulse restarts the idle count.
        repeat (10) tick();
        bus_if.iHostCs_n  = 2'b10;
        bus_if.iBypassReq = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("idle_cs_low_busy", 8'(bus_if.oBusy), 8'h0);
        end
        bus_if.iHostCs_n = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_pre_pulse_busy", 8'(bus_if.oBusy), 8'h0);
        end
        bus_if.iHostCs_n = 2'b10;
        tick();
        chk("idle_pulse_busy", 8'(bus_if.oBusy), 8'h0);
        bus_if.iHostCs_n = 2'b11;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("idle_restart_busy", 8'(bus_if.oBusy), 8'h0);
        end
        tick();
        chk("idle_handover_busy", 8'(bus_if.oBusy), 8'h1);
        chk("idle_handover_rst",  8'(bus_if.oSpiRst_n), 8'h2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
